// File: rtl/reg_file_scoreboard_if.sv
// Purpose: bundle of write-back, issue and read-port signals between decode/write-back and the register file.
// Latency: n/a (wires only).
// Backpressure: stall is the only backpressure signal; decode holds its issue while it is high.
//
// Signals:
//   wb_valid/wb_gpr/wb_fpr/wb_dst/wb_data : write-back retire strobe, target file flags, index, result
//   iss_valid/iss_gpr/iss_fpr/iss_dst     : issue strobe, destination file flags, destination index
//   rs_a/rt_a/fs_a/ft_a, src_use          : read addresses and source-used mask {ft,fs,rt,rs}
//   rs_d/rt_d/fs_d/ft_d, stall            : read data and decode stall
interface reg_file_scoreboard_if #(
    parameter int AW    = 5,
    parameter int REG_W = 32
);
    logic             wb_valid;
    logic             wb_gpr;
    logic             wb_fpr;
    logic [AW-1:0]    wb_dst;
    logic [REG_W-1:0] wb_data;

    logic             iss_valid;
    logic             iss_gpr;
    logic             iss_fpr;
    logic [AW-1:0]    iss_dst;

    logic [AW-1:0]    rs_a;
    logic [AW-1:0]    rt_a;
    logic [AW-1:0]    fs_a;
    logic [AW-1:0]    ft_a;
    logic [3:0]       src_use;

    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic [REG_W-1:0] fs_d;
    logic [REG_W-1:0] ft_d;
    logic             stall;

    // Decode / write-back side
    modport master (
        output wb_valid, wb_gpr, wb_fpr, wb_dst, wb_data,
        output iss_valid, iss_gpr, iss_fpr, iss_dst,
        output rs_a, rt_a, fs_a, ft_a, src_use,
        input  rs_d, rt_d, fs_d, ft_d, stall
    );

    // Register file side
    modport slave (
        input  wb_valid, wb_gpr, wb_fpr, wb_dst, wb_data,
        input  iss_valid, iss_gpr, iss_fpr, iss_dst,
        input  rs_a, rt_a, fs_a, ft_a, src_use,
        output rs_d, rt_d, fs_d, ft_d, stall
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Purpose: 32 GPR + 32 FPR architectural register file with per-register busy scoreboard and RAW stall.
// Latency: writes visible one edge later (same cycle when REGFILE_BYPASS_EN is defined); reads combinational.
// Backpressure: stall asserted while any used source is busy; an issue seen while stalled is dropped.
//
// Ports:
//   clk  : core clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (clears both files and all busy bits)
//   bus  : reg_file_scoreboard_if.slave (write-back, issue, four read ports, stall)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back data to the
// read ports and to mask the busy bit that write-back is clearing out of stall.
module reg_file_scoreboard #(
    parameter int NUM_REG = 32,
    parameter int AW      = 5,
    parameter int REG_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_file_scoreboard_if.slave   bus
);

    logic [REG_W-1:0]   r_gpr [NUM_REG];
    logic [REG_W-1:0]   r_fpr [NUM_REG];
    logic [NUM_REG-1:0] r_gpr_busy;
    logic [NUM_REG-1:0] r_fpr_busy;

    logic               w_wr_gpr;
    logic               w_wr_fpr;
    logic [NUM_REG-1:0] w_gpr_clr;
    logic [NUM_REG-1:0] w_fpr_clr;
    logic [NUM_REG-1:0] w_gpr_set;
    logic [NUM_REG-1:0] w_fpr_set;
    logic [NUM_REG-1:0] w_gpr_busy_eff;
    logic [NUM_REG-1:0] w_fpr_busy_eff;
    logic               w_stall;
    logic               w_accept;

    // GPR wins when both flags are set; GPR0 writes are dropped. Reset masks both.
    assign w_wr_gpr = bus.wb_valid & bus.wb_gpr & (bus.wb_dst != '0) & ~rst;
    assign w_wr_fpr = bus.wb_valid & ~bus.wb_gpr & bus.wb_fpr & ~rst;

    always_comb begin
        w_gpr_clr = '0;
        w_fpr_clr = '0;
        if (w_wr_gpr) w_gpr_clr[bus.wb_dst] = 1'b1;
        if (w_wr_fpr) w_fpr_clr[bus.wb_dst] = 1'b1;
    end

`ifdef REGFILE_BYPASS_EN
    // A register being retired this cycle no longer holds up its consumer.
    assign w_gpr_busy_eff = r_gpr_busy & ~w_gpr_clr;
    assign w_fpr_busy_eff = r_fpr_busy & ~w_fpr_clr;
`else
    assign w_gpr_busy_eff = r_gpr_busy;
    assign w_fpr_busy_eff = r_fpr_busy;
`endif

    assign w_stall = (bus.src_use[0] & w_gpr_busy_eff[bus.rs_a])
                   | (bus.src_use[1] & w_gpr_busy_eff[bus.rt_a])
                   | (bus.src_use[2] & w_fpr_busy_eff[bus.fs_a])
                   | (bus.src_use[3] & w_fpr_busy_eff[bus.ft_a]);

    assign bus.stall = w_stall;
    assign w_accept  = bus.iss_valid & ~w_stall & ~rst;

    // GPR takes priority over FPR on issue too; GPR0 is never marked busy.
    always_comb begin
        w_gpr_set = '0;
        w_fpr_set = '0;
        if (w_accept) begin
            if (bus.iss_gpr) begin
                if (bus.iss_dst != '0) w_gpr_set[bus.iss_dst] = 1'b1;
            end else if (bus.iss_fpr) begin
                w_fpr_set[bus.iss_dst] = 1'b1;
            end
        end
    end

    function automatic logic [REG_W-1:0] read_gpr(input logic [AW-1:0] addr);
        logic [REG_W-1:0] v;
        v = r_gpr[addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_gpr && (bus.wb_dst == addr)) v = bus.wb_data;
`endif
        if (addr == '0) v = '0;
        return v;
    endfunction

    function automatic logic [REG_W-1:0] read_fpr(input logic [AW-1:0] addr);
        logic [REG_W-1:0] v;
        v = r_fpr[addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_fpr && (bus.wb_dst == addr)) v = bus.wb_data;
`endif
        return v;
    endfunction

    assign bus.rs_d = read_gpr(bus.rs_a);
    assign bus.rt_d = read_gpr(bus.rt_a);
    assign bus.fs_d = read_fpr(bus.fs_a);
    assign bus.ft_d = read_fpr(bus.ft_a);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_gpr[i] <= '0;
                r_fpr[i] <= '0;
            end
            r_gpr_busy <= '0;
            r_fpr_busy <= '0;
        end else begin
            if (w_wr_gpr) r_gpr[bus.wb_dst] <= bus.wb_data;
            if (w_wr_fpr) r_fpr[bus.wb_dst] <= bus.wb_data;
            // Set after clear: a same-cycle new producer keeps the register busy.
            r_gpr_busy <= (r_gpr_busy & ~w_gpr_clr) | w_gpr_set;
            r_fpr_busy <= (r_fpr_busy & ~w_fpr_clr) | w_fpr_set;
        end
    end

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Architectural register-file and hazard scoreboard for the core: the receiving end of the write-back phase. It holds 32 GPRs and 32 FPRs, commits write-back results (`wb_data` qualified by the write-back's GPR/FPR update flags), and serves four combinational read ports to decode. A per-register busy scoreboard is set at issue and cleared at write-back, and drives a decode stall on read-after-write hazards.

## Interface

Parameters:
- `NUM_REG`, default 32: registers per file (GPR and FPR each).
- `AW`, default 5: register address width; `2**AW == NUM_REG`.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  write-back retire strobe.
- `wb_gpr`  in  1  write-back targets GPR file.
- `wb_fpr`  in  1  write-back targets FPR file.
- `wb_dst`  in  AW  write-back destination index.
- `wb_data`  in  `REG_W`  write-back result.
- `iss_valid`  in  1  decode issues an instruction this cycle.
- `iss_gpr`  in  1  issued instruction writes a GPR.
- `iss_fpr`  in  1  issued instruction writes an FPR.
- `iss_dst`  in  AW  issued destination index.
- `rs_a`, `rt_a`  in  AW each  GPR read addresses.
- `fs_a`, `ft_a`  in  AW each  FPR read addresses.
- `src_use`  in  4  source-used mask {ft, fs, rt, rs}, bit 0 = rs.
- `rs_d`, `rt_d`, `fs_d`, `ft_d`  out  `REG_W` each  read data.
- `stall`  out  1  decode must hold; the issue is not accepted.

## Operation

- Write: on an edge with `wb_valid` high, `wb_gpr` high writes GPR[`wb_dst`]; `wb_fpr` high writes FPR[`wb_dst`]. When both are high, only the GPR is written.
- GPR0 is hardwired to 0. Writes to it are dropped, and it is never busy. FPR0 is an ordinary register.
- Read: all four ports are combinational from the arrays, with bypass per Configuration.
- Scoreboard: there is one busy bit per register per file.
  - An accepted issue (`iss_valid & ~stall`) sets busy[`iss_dst`] in the GPR set if `iss_gpr`, otherwise in the FPR set if `iss_fpr`.
  - A write-back clears busy[`wb_dst`] in the file it writes.
- Simultaneous issue and write-back to the same register and file: busy stays 1, because the new producer wins. The data write still occurs.
- Write-back to a non-busy register: the data is written and busy stays 0.
- `stall` = OR over enabled sources of the busy bit of that source. The rs/rt sources check GPR busy; the fs/ft sources check FPR busy.
- `iss_valid` high while `stall` high: the issue is ignored and no busy bit changes.

## Timing

- Write latency is 1 edge: data is visible on the read ports in the cycle after the write edge, or in the same cycle with bypass.
- Busy set and clear take effect at the edge. `stall` reflects the registered busy state combinationally, plus the same-cycle write-back term under bypass.
- Reset: on an edge with `rst` high, all registers go to 0 and all busy bits to 0. After that edge, every `*_d` output reads 0 and `stall` = 0.
- While `rst` is high, write-back and issue inputs in the same cycle are ignored. An in-flight producer across reset never clears a busy bit, because none is set.
- Address wrap is not applicable: `AW` fully covers `NUM_REG`.

## Configuration

- `REGFILE_BYPASS_EN` defined:
  - A read whose address matches a same-cycle write (`wb_valid`, same file, nonzero GPR index) returns `wb_data`.
  - The busy bit being cleared by that write-back does not contribute to `stall`.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return array contents only.
  - `stall` uses the registered busy bits only, so a consumer waits one extra cycle after write-back.

## Test plan

- Reset, then write GPR5=0x0000_1234 → next cycle `rs_a`=5 reads 0x0000_1234; a write to GPR0=0xFFFF_FFFF → GPR0 still reads 0.
- Issue GPR7 with `src_use`=0, then `rs_a`=7 with `src_use`=0001 → `stall`=1 until write-back of GPR7. With bypass, `stall` drops in the write-back cycle and `rs_d`=`wb_data`. Without bypass, `stall` drops one cycle later.
- Same cycle: issue FPR3, and write back FPR3=0x3F80_0000 → FPR3=0x3F80_0000, busy[3] stays 1, and `fs_a`=3 stalls.
- Write back with `wb_gpr`=`wb_fpr`=1, `wb_dst`=4, data 0xAA → GPR4=0xAA, FPR4 unchanged (0).
- Issue GPR9 while `stall`=1 → GPR9 not busy afterward; `rt_a`=9 with `src_use`=0010 gives `stall`=0.
- Set busy on GPR2 and FPR2, write data, then assert `rst` → all reads are 0, `stall`=0, and a stale write-back of GPR2 asserted concurrently with `rst` is ignored.
